// File: rtl/enigma_encryptor.sv
// Three-rotor Enigma (rotors I-II-III, reflector B) behind a 1 Mbaud 8N1 UART, showing the last
// plaintext/ciphertext pair on a 4-digit 7-segment display and the LEDs.
module enigma_encryptor #(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned BAUD         = 1_000_000,
   parameter int unsigned REFRESH_BITS = 18
) (
   input  logic       msclk,
   input  logic       btnS,
   input  logic       btnR,
   input  logic       sw0,
   input  logic       sw1,
   input  logic       sw2,
   input  logic       sw3,
   input  logic       sw4,
   input  logic       sw5,
   input  logic       sw6,
   input  logic       sw7,
   input  logic       RX,
   output logic       TX,
   output logic [3:0] an,
   output logic [7:0] seg,
   output logic [7:0] Led
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   // Wiring tables as ASCII strings; character k is the output letter for contact k.
   localparam logic [207:0] ROTOR1 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
   localparam logic [207:0] ROTOR2 = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
   localparam logic [207:0] ROTOR3 = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
   localparam logic [207:0] REFL_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

   function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
   endfunction

   function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
      return (a >= b) ? 5'(a - b) : 5'({1'b0, a} + 6'd26 - {1'b0, b});
   endfunction

   function automatic logic [4:0] inc26(input logic [4:0] a);
      return (a == 5'd25) ? 5'd0 : 5'(a + 5'd1);
   endfunction

   function automatic logic [4:0] wire_fwd(input logic [207:0] w, input logic [4:0] c);
      int unsigned b;
      b = 8 * (25 - int'(c));
      return 5'(w[b +: 8] - 8'd65);
   endfunction

   function automatic logic [4:0] wire_inv(input logic [207:0] w, input logic [4:0] c);
      logic [4:0] r;
      r = '0;
      for (int j = 0; j < 26; j++) begin
         if (wire_fwd(w, 5'(j)) == c) r = 5'(j);
      end
      return r;
   endfunction

   function automatic logic [4:0] encrypt(input logic [4:0] c, input logic [4:0] pl,
                                          input logic [4:0] pm, input logic [4:0] pr);
      logic [4:0] x;
      x = sub26(wire_fwd(ROTOR3, add26(c, pr)), pr);
      x = sub26(wire_fwd(ROTOR2, add26(x, pm)), pm);
      x = sub26(wire_fwd(ROTOR1, add26(x, pl)), pl);
      x = wire_fwd(REFL_B, x);
      x = sub26(wire_inv(ROTOR1, add26(x, pl)), pl);
      x = sub26(wire_inv(ROTOR2, add26(x, pm)), pm);
      x = sub26(wire_inv(ROTOR3, add26(x, pr)), pr);
      return x;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      g = 7'h00;
      unique case (n)
         4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
         4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
         4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
         4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  4'hF: g = 7'h71;
      endcase
      return g;
   endfunction

   logic [7:0] key;
   assign key = {sw7, sw6, sw5, sw4, sw3, sw2, sw1, sw0};

   // Input synchronisers
   logic [1:0] rx_sync_q, btnr_sync_q;
   logic       rx_prev_q, rx_s, reload;

   always_ff @(posedge msclk or negedge btnS) begin
      if (!btnS) begin
         rx_sync_q   <= 2'b11;
         btnr_sync_q <= 2'b00;
         rx_prev_q   <= 1'b1;
      end else begin
         rx_sync_q   <= {rx_sync_q[0], RX};
         btnr_sync_q <= {btnr_sync_q[0], btnR};
         rx_prev_q   <= rx_sync_q[1];
      end
   end

   assign rx_s   = rx_sync_q[1];
   assign reload = btnr_sync_q[1];

   // UART receiver
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   rx_state_e      rx_state_q, rx_state_d;
   logic [CW-1:0]  rx_cnt_q;
   logic [2:0]     rx_bit_q;
   logic [7:0]     rx_shift_q;
   logic           rx_valid;

   always_ff @(posedge msclk or negedge btnS) begin
      if (!btnS) rx_state_q <= RxIdle;
      else       rx_state_q <= rx_state_d;
   end

   always_comb begin
      rx_state_d = rx_state_q;
      unique case (rx_state_q)
         RxIdle:  if (rx_prev_q && !rx_s) rx_state_d = RxStart;
         RxStart: if (rx_cnt_q == HALF_LAST) rx_state_d = rx_s ? RxIdle : RxData;
         RxData:  if (rx_cnt_q == BIT_LAST && rx_bit_q == 3'd7) rx_state_d = RxStop;
         RxStop:  if (rx_cnt_q == BIT_LAST) rx_state_d = RxIdle;
      endcase
   end

   always_comb begin
      rx_valid = (rx_state_q == RxStop) && (rx_cnt_q == BIT_LAST) && rx_s;
   end

   always_ff @(posedge msclk or negedge btnS) begin
      if (!btnS) begin
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         unique case (rx_state_q)
            RxIdle: begin
               rx_cnt_q <= '0;
               rx_bit_q <= '0;
            end
            RxStart: rx_cnt_q <= (rx_cnt_q == HALF_LAST) ? '0 : rx_cnt_q + 1'b1;
            RxData: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= rx_bit_q + 1'b1;
                  rx_shift_q <= {rx_s, rx_shift_q[7:1]};
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RxStop: rx_cnt_q <= (rx_cnt_q == BIT_LAST) ? '0 : rx_cnt_q + 1'b1;
         endcase
      end
   end

   // Rotor positions; the effective value follows the switches until the first clock after reset
   logic [4:0] start_r, start_m;
   logic       load_q, use_start;
   logic [4:0] pos_l_q, pos_m_q, pos_r_q, pos_l, pos_m, pos_r;
   logic [4:0] nxt_l, nxt_m, nxt_r;
   logic       is_upper, is_lower, is_letter, accept, tx_load;
   logic [4:0] letter, enc;
   logic [7:0] out_byte;
   logic [7:0] buf_q, plain_q, ciph_q;
   logic       buf_valid_q;

   assign start_r   = (key[4:0] >= 5'd26) ? 5'(key[4:0] - 5'd26) : key[4:0];
   assign start_m   = {2'b00, key[7:5]};
   assign use_start = load_q || reload;
   assign pos_l     = use_start ? 5'd0 : pos_l_q;
   assign pos_m     = use_start ? start_m : pos_m_q;
   assign pos_r     = use_start ? start_r : pos_r_q;

   always_comb begin
      nxt_r = inc26(pos_r);
      nxt_m = (pos_r == 5'd21 || pos_m == 5'd4) ? inc26(pos_m) : pos_m;
      nxt_l = (pos_m == 5'd4) ? inc26(pos_l) : pos_l;
   end

   assign is_upper  = (rx_shift_q >= 8'h41) && (rx_shift_q <= 8'h5A);
   assign is_lower  = (rx_shift_q >= 8'h61) && (rx_shift_q <= 8'h7A);
   assign is_letter = is_upper || is_lower;
   assign letter    = 5'(rx_shift_q - (is_upper ? 8'h41 : 8'h61));
   assign enc       = encrypt(letter, nxt_l, nxt_m, nxt_r);
   assign out_byte  = is_letter ? 8'h41 + {3'b000, enc} : rx_shift_q;
   assign accept    = rx_valid && !buf_valid_q;

   always_ff @(posedge msclk or negedge btnS) begin
      if (!btnS) begin
         load_q  <= 1'b1;
         pos_l_q <= '0;
         pos_m_q <= '0;
         pos_r_q <= '0;
      end else begin
         load_q <= 1'b0;
         if (reload) begin
            pos_l_q <= 5'd0;
            pos_m_q <= start_m;
            pos_r_q <= start_r;
         end else if (accept && is_letter) begin
            pos_l_q <= nxt_l;
            pos_m_q <= nxt_m;
            pos_r_q <= nxt_r;
         end else begin
            pos_l_q <= pos_l;
            pos_m_q <= pos_m;
            pos_r_q <= pos_r;
         end
      end
   end

   always_ff @(posedge msclk or negedge btnS) begin
      if (!btnS) begin
         buf_q       <= '0;
         buf_valid_q <= 1'b0;
         plain_q     <= '0;
         ciph_q      <= '0;
      end else begin
         if (accept) begin
            buf_q       <= out_byte;
            buf_valid_q <= 1'b1;
            plain_q     <= rx_shift_q;
            ciph_q      <= out_byte;
         end else if (tx_load) begin
            buf_valid_q <= 1'b0;
         end
      end
   end

   // UART transmitter; a pending byte is loaded as the previous stop bit ends, so frames abut
   typedef enum logic {TxIdle, TxSend} tx_state_e;
   tx_state_e     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q;
   logic [3:0]    tx_bit_q;
   logic [9:0]    tx_shift_q;
   logic          tx_q, tx_d, frame_end;

   assign frame_end = (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

   always_ff @(posedge msclk or negedge btnS) begin
      if (!btnS) tx_state_q <= TxIdle;
      else       tx_state_q <= tx_state_d;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      unique case (tx_state_q)
         TxIdle: if (buf_valid_q) tx_state_d = TxSend;
         TxSend: if (frame_end && !buf_valid_q) tx_state_d = TxIdle;
      endcase
   end

   always_comb begin
      tx_load = buf_valid_q && ((tx_state_q == TxIdle) || frame_end);
      tx_d    = (tx_state_q == TxSend) ? tx_shift_q[0] : 1'b1;
   end

   always_ff @(posedge msclk or negedge btnS) begin
      if (!btnS) begin
         tx_q       <= 1'b1;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
      end else begin
         tx_q <= tx_d;
         if (tx_load) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= {1'b1, buf_q, 1'b0};
         end else if (tx_state_q == TxSend) begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_q   <= '0;
               tx_bit_q   <= tx_bit_q + 1'b1;
               tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            end else begin
               tx_cnt_q <= tx_cnt_q + 1'b1;
            end
         end
      end
   end

   // Display multiplexing
   logic [REFRESH_BITS-1:0] refresh_cnt_q;
   logic [1:0]              sel;
   logic [3:0]              nib, an_q;
   logic [7:0]              seg_q;

   assign sel = refresh_cnt_q[REFRESH_BITS-1 -: 2];

   always_comb begin
      nib = 4'h0;
      unique case (sel)
         2'd0: nib = ciph_q[3:0];
         2'd1: nib = ciph_q[7:4];
         2'd2: nib = plain_q[3:0];
         2'd3: nib = plain_q[7:4];
      endcase
   end

   always_ff @(posedge msclk or negedge btnS) begin
      if (!btnS) begin
         refresh_cnt_q <= '0;
         an_q          <= 4'hF;
         seg_q         <= 8'hFF;
      end else begin
         refresh_cnt_q <= refresh_cnt_q + 1'b1;
         an_q          <= ~(4'b0001 << sel);
         seg_q         <= {1'b1, ~glyph(nib)};
      end
   end

   assign TX  = tx_q;
   assign an  = an_q;
   assign seg = seg_q;
   assign Led = ciph_q;

endmodule

// File: tb/tb_enigma_encryptor.sv
// Directed bench for enigma_encryptor: drives 8N1 frames on RX and decodes TX with a serial peer.
module tb_enigma_encryptor;

   logic       msclk, btnS, btnR, RX;
   logic [7:0] sw;
   logic       TX;
   logic [3:0] an;
   logic [7:0] seg, Led;

   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned last_stop_mid = 0;
   logic [7:0]  rxq[$];
   int unsigned fallq[$];

   enigma_encryptor #(
      .CLK_HZ(100_000_000),
      .BAUD(1_000_000),
      .REFRESH_BITS(10)
   ) dut (
      .msclk(msclk), .btnS(btnS), .btnR(btnR),
      .sw0(sw[0]), .sw1(sw[1]), .sw2(sw[2]), .sw3(sw[3]),
      .sw4(sw[4]), .sw5(sw[5]), .sw6(sw[6]), .sw7(sw[7]),
      .RX(RX), .TX(TX), .an(an), .seg(seg), .Led(Led)
   );

   initial msclk = 1'b0;
   always #5 msclk = ~msclk;
   always @(posedge msclk) cyc++;

   // Serial peer on TX: samples each bit near its centre, keeps frames with a valid stop bit
   initial begin
      logic [7:0] d;
      forever begin
         @(negedge TX);
         fallq.push_back(cyc);
         repeat (50) @(negedge msclk);
         for (int i = 0; i < 8; i++) begin
            repeat (100) @(negedge msclk);
            d[i] = TX;
         end
         repeat (100) @(negedge msclk);
         if (TX === 1'b1) rxq.push_back(d);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stopb);
      RX = 1'b0;
      repeat (100) @(negedge msclk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (100) @(negedge msclk);
      end
      RX = stopb;
      last_stop_mid = cyc + 50;
      repeat (100) @(negedge msclk);
      RX = 1'b1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
   endtask

   task automatic expect_str(input string tag, input string exp);
      int k;
      k = 0;
      while (rxq.size() < exp.len() && k < 3000) begin
         @(negedge msclk);
         k++;
      end
      chk($sformatf("%s_count", tag), rxq.size(), exp.len());
      for (int i = 0; i < exp.len(); i++) begin
         if (i < rxq.size()) chk($sformatf("%s[%0d]", tag, i), rxq[i], exp[i]);
      end
      rxq.delete();
   endtask

   task automatic do_reset(input logic [7:0] key);
      btnS = 1'b0;
      sw   = key;
      repeat (20) @(negedge msclk);
      btnS = 1'b1;
      repeat (20) @(negedge msclk);
      rxq.delete();
      fallq.delete();
   endtask

   initial begin
      logic [7:0]  dig[4];
      int          bad;
      int unsigned stop_mid0;
      btnS = 1'b0;
      btnR = 1'b0;
      RX   = 1'b1;
      sw   = 8'h00;
      repeat (20) @(negedge msclk);
      chk("reset_tx", TX, 1'b1);
      chk("reset_led", Led, 8'h00);
      chk("reset_an", an, 4'hF);
      chk("reset_seg", seg, 8'hFF);
      btnS = 1'b1;
      repeat (20) @(negedge msclk);

      // Back-to-back frames, start AAA
      send(8'h41, 1'b1);
      stop_mid0 = last_stop_mid;
      send_str("AAAA");
      chk("tx_latency_ok", (fallq.size() > 0) && (fallq[0] - stop_mid0 <= 12), 1'b1);
      expect_str("upper", "BDZGO");
      chk("led_upper", Led, 8'h4F);

      do_reset(8'h00);
      send_str("aaaaa");
      expect_str("lower", "BDZGO");
      chk("led_lower", Led, 8'h4F);
      dig = '{default: 8'h00};
      bad = 0;
      repeat (1100) begin
         @(negedge msclk);
         case (an)
            4'b1110: dig[0] = seg;
            4'b1101: dig[1] = seg;
            4'b1011: dig[2] = seg;
            4'b0111: dig[3] = seg;
            default: bad++;
         endcase
      end
      chk("an_onehot", bad, 0);
      chk("digit3_6", dig[3], 8'h82);
      chk("digit2_1", dig[2], 8'hF9);
      chk("digit1_4", dig[1], 8'h99);
      chk("digit0_F", dig[0], 8'h8E);

      do_reset(8'h00);
      send_str("A A");
      expect_str("space", "B D");

      // Middle rotor turnover from V, then repeated after a fresh reset
      do_reset(8'h15);
      send_str("A");
      expect_str("notch1", "U");
      do_reset(8'h15);
      send_str("AA");
      expect_str("notch2", "UQ");

      do_reset(8'h80);
      send_str("A");
      expect_str("double_step", "F");

      do_reset(8'h1F);
      send_str("A");
      expect_str("key_wrap", "W");

      // Reset during a TX frame, held for 100 us
      send_str("A");
      repeat (300) @(negedge msclk);
      btnS = 1'b0;
      sw   = 8'h02;
      @(negedge msclk);
      chk("tx_abort", TX, 1'b1);
      bad = 0;
      repeat (10000) begin
         @(negedge msclk);
         if (TX !== 1'b1 || an !== 4'hF || seg !== 8'hFF) bad++;
      end
      chk("reset_hold", bad, 0);
      btnS = 1'b1;
      repeat (20) @(negedge msclk);
      rxq.delete();
      fallq.delete();

      send_str("A");
      expect_str("key02_first", "Z");
      btnR = 1'b1;
      repeat (5) @(negedge msclk);
      btnR = 1'b0;
      repeat (10) @(negedge msclk);
      send_str("A");
      expect_str("after_reload", "Z");
      send_str("A");
      expect_str("after_reload_next", "G");
      btnR = 1'b1;
      repeat (5) @(negedge msclk);
      send_str("AA");
      expect_str("btnr_held", "ZZ");
      btnR = 1'b0;
      repeat (10) @(negedge msclk);

      // Framing error and a short glitch must neither transmit nor step
      send(8'h41, 1'b0);
      repeat (1500) @(negedge msclk);
      chk("bad_stop_no_tx", rxq.size(), 0);
      RX = 1'b0;
      repeat (2) @(negedge msclk);
      RX = 1'b1;
      repeat (1500) @(negedge msclk);
      chk("glitch_no_tx", rxq.size(), 0);
      send_str("A");
      expect_str("no_step", "Z");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/enigma_encryptor.md
# enigma_encryptor

Top-level FPGA block implementing a three-rotor Enigma cipher behind a 1 Mbaud UART. ASCII letters received on RX are encrypted and sent back on TX. Board switches set the starting rotor positions. The last plaintext/ciphertext pair is shown on the 4-digit 7-segment display and the LEDs. It sits directly on the board pins; `model_uart` is only the bench-side serial peer.

## Interface
- CLK_HZ, 100_000_000, clock frequency.
- BAUD, 1_000_000, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (100).
- REFRESH_BITS, 18, display refresh counter width.

Ports:
- msclk  in  1  system clock, 100 MHz.
- btnS  in  1  reset; asynchronous, active-low.
- btnR  in  1  rotor reload request, active-high; 2-FF synchronised.
- sw0..sw7  in  1 each  key switches; key = {sw7..sw0}.
- RX  in  1  UART receive, 8N1, idle high; 2-FF synchronised.
- TX  out  1  UART transmit, 8N1, idle high.
- an  out  4  digit enables, active-low; an[0] is the rightmost digit.
- seg  out  8  segments, active-low; seg[6:0] = {g,f,e,d,c,b,a}; seg[7] = dp, always 1 (off).
- Led  out  8  last ciphertext byte.

## Operation
- Cipher definition:
  - Rotors, left→right: I (EKMFLGDQVZNTOWYHXUSPAIBRCJ), II (AJDKSIRUXBLHWTMCQGZNPYFVOE), III (BDFHJLCPRTXVZNYEIWGAKMUSQO).
  - Reflector B (YRUHQSLDPXNGOKMIEBFZCWVJAT).
  - No plugboard; ring settings all A.
- Start positions (0 = A) are loaded at reset release and while synced btnR = 1:
  - right = key[4:0], reduced by 26 if ≥ 26.
  - middle = key[7:5].
  - left = 0.
- Stepping happens before each encryption:
  - Right rotor always steps.
  - Middle steps if right was at V (21), or if middle was at E (4) (double step).
  - Left steps if middle was at E.
  - Positions wrap 25→0.
- Signal path: right→middle→left forward, reflector, left→middle→right inverse. Contact index = (in + pos) mod 26 on entry, (out − pos) mod 26 on exit; all arithmetic mod 26.
- Input handling:
  - 'A'..'Z' and 'a'..'z' are folded to 0..25, stepped, encrypted, and output as uppercase ASCII.
  - Any other byte is echoed unchanged; rotors do not step.
- UART RX:
  - Falling edge starts reception; start bit is re-checked at its mid-point, and a glitch returns to idle.
  - 8 data bits are sampled at bit centres, LSB first.
  - Stop bit must be 1, otherwise the byte is discarded.
- One-byte pending buffer between cipher and TX.
  - If a byte completes while the buffer is full, the new byte is dropped and rotors do not step.
- UART TX sends 1 start bit, 8 data bits LSB first, and 1 stop bit. Each bit lasts CLKS_PER_BIT cycles.
- Display:
  - Digits 3..2 show the plaintext byte in hex; digits 1..0 show the ciphertext byte in hex.
  - Digit select = refresh_cnt[REFRESH_BITS-1:REFRESH_BITS-2]; one enable low at a time.
  - Hex glyphs use standard 0–F patterns.
- Led = last ciphertext byte.
- btnR held high: rotors stay at start positions; each encryption then steps from the loaded position.

## Timing
- Reset (btnS = 0) values:
  - Outputs: TX = 1, Led = 0, an = 4'b1111, seg = 8'hFF.
  - Internal: rotors = switch-derived start positions; buffer empty; refresh counter 0.
- Reset asserted mid-frame aborts RX and TX immediately. TX returns to 1 and no partial frame resumes.
- Cipher latency: ≤ 4 cycles from stop-bit mid-sample to pending-buffer valid.
- TX start bit begins ≤ 8 cycles after the stop-bit mid-sample when the transmitter is idle.
- Otherwise TX starts the cycle after the previous stop bit ends; frames are back-to-back with no gap.
- Sustained back-to-back RX at BAUD must lose no bytes.
- Led and display registers update in the same cycle the ciphertext enters the pending buffer.
- Simultaneous btnR reload and encryption step: reload wins.

## Test plan
- key = 0x00, send "AAAAA" → TX returns "BDZGO"; Led = 0x4F ('O') at end.
- key = 0x00, send "aaaaa" → "BDZGO"; digits 3..2 show 61, digits 1..0 show 4F.
- key = 0x00, send "A A" → 'B', ' ', 'D'; the space does not step the rotors.
- key = 0x15 (right = V), send 'A' → middle rotor steps (positions A,B,W). Verify by a second reset with key 0x15 and reference-model output.
- btnS low for 100 µs with key = 0x02 → TX held 1, an = 1111 throughout. Release, send 'A' → output matches the model for start A,A,C. Pulse btnR between characters → the next output equals the first.
- Stop bit forced 0 → no TX frame and no rotor step. A 2-cycle RX glitch → ignored.
